// File: rtl/pet_loader_pkg.sv
// Shared types and BASIC4 constants for the PET PRG/ROM DMA loader.
// The AUTORUN state exists only when PRG_LOADER_AUTORUN_EN is defined.
package pet_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      ROM,
      PATCH,
`ifdef PRG_LOADER_AUTORUN_EN
      AUTORUN,
`endif
      DONE
   } state_t;

   localparam int BASIC4_PTR_BASE   = 'h002A;
   localparam int KEYBUF_ADDR       = 'h026F;
   localparam int KEYCOUNT_ADDR     = 'h009E;
   localparam int AUTORUN_KEY_COUNT = 4;

   // PETSCII "RUN" followed by carriage return
   localparam logic [7:0] AUTORUN_KEYS [AUTORUN_KEY_COUNT] = '{8'h52, 8'h55, 8'h4E, 8'h0D};

   function automatic logic [7:0] ptr_byte(input logic [15:0] value, input logic hi);
      return hi ? value[15:8] : value[7:0];
   endfunction

endpackage

// File: rtl/prg_dma_loader_if.sv
// Bundle of the HPS ioctl download stream, the DMA write port and loader status.
interface prg_dma_loader_if #(
   parameter int ADDR_W = 16
);
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              ioctl_wait;
   logic [ADDR_W-1:0] dma_addr;
   logic [7:0]        dma_din;
   logic              dma_we;
   logic              dma_busy;
   logic [ADDR_W-1:0] load_end;
   logic              overflow;
   logic              done;

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_busy,
      output ioctl_wait, dma_addr, dma_din, dma_we, load_end, overflow, done
   );

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_busy,
      input  ioctl_wait, dma_addr, dma_din, dma_we, load_end, overflow, done
   );
endinterface

// File: rtl/prg_dma_loader_slot.sv
// dma_write_slot: one-entry write buffer in front of the DMA port with busy handshake.
module dma_write_slot #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_data,
   input  logic              busy,
   output logic              full,
   output logic              ready,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data
);

   logic valid;

   assign full  = valid;
   assign we    = valid & ~busy;
   // ready also covers the drain-through case so PATCH can issue one write per cycle
   assign ready = ~valid | ~busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         addr  <= '0;
         data  <= '0;
      end else if (req) begin
         valid <= 1'b1;
         addr  <= req_addr;
         data  <= req_data;
      end else if (we) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/prg_dma_loader.sv
// prg_dma_loader: writes HPS PRG/ROM downloads into PET memory and patches BASIC pointers.
// Define PRG_LOADER_AUTORUN_EN to also type RUN<CR> into the keyboard buffer after a PRG load.
module prg_dma_loader
   import pet_loader_pkg::*;
#(
   parameter int         ADDR_W     = 16,
   parameter int         RAM_TOP    = 'h8000,
   parameter logic [7:0] PRG_INDEX  = 8'h41,
   parameter logic [7:0] ROM_INDEX  = 8'h00,
   parameter int         ROM_LO     = 'h0400,
   parameter int         ROM_HI     = 'h8000,
   parameter int         ROM_OFFSET = 'h8000,
   parameter int         PTR_BASE   = BASIC4_PTR_BASE,
   parameter int         PTR_COUNT  = 3
) (
   input logic             clk,
   input logic             reset_n,
   prg_dma_loader_if.slave bus
);

   localparam int PATCH_LEN = 2 * PTR_COUNT;

   state_t            state, state_n;
   logic              dl_q;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [ADDR_W-1:0] load_end_q, load_end_n;
   logic              overflow_q, overflow_n;
   logic [7:0]        idx, idx_n;
   logic              req;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_data;
   logic              slot_full, slot_ready;
   logic              rise, in_rom;

   assign rise   = bus.ioctl_download & ~dl_q;
   assign in_rom = (bus.ioctl_addr >= 25'(ROM_LO)) && (bus.ioctl_addr < 25'(ROM_HI));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         dl_q       <= 1'b0;
         ptr        <= '0;
         load_end_q <= '0;
         overflow_q <= 1'b0;
         idx        <= '0;
      end else begin
         state      <= state_n;
         dl_q       <= bus.ioctl_download;
         ptr        <= ptr_n;
         load_end_q <= load_end_n;
         overflow_q <= overflow_n;
         idx        <= idx_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      load_end_n = load_end_q;
      overflow_n = overflow_q;
      idx_n      = idx;
      req        = 1'b0;
      req_addr   = ptr;
      req_data   = bus.ioctl_dout;
      case (state)
         IDLE: begin
            if (rise && bus.ioctl_index == PRG_INDEX) begin
               state_n    = HDR;
               overflow_n = 1'b0;
               ptr_n      = '0;
            end else if (rise && bus.ioctl_index == ROM_INDEX) begin
               state_n    = ROM;
               overflow_n = 1'b0;
            end
         end
         HDR: begin
            if (!bus.ioctl_download) begin
               state_n = IDLE;
            end else if (bus.ioctl_wr && bus.ioctl_addr == 25'd0) begin
               ptr_n[7:0] = bus.ioctl_dout;
            end else if (bus.ioctl_wr && bus.ioctl_addr == 25'd1) begin
               ptr_n[15:8] = bus.ioctl_dout;
               state_n     = DATA;
            end
         end
         DATA: begin
            if (!bus.ioctl_download) begin
               load_end_n = ptr;
               idx_n      = '0;
               state_n    = PATCH;
            end else if (bus.ioctl_wr) begin
               // a full slot here means the HPS ignored ioctl_wait
               if (slot_full || ptr >= ADDR_W'(RAM_TOP)) begin
                  overflow_n = 1'b1;
               end else begin
                  req   = 1'b1;
                  ptr_n = ptr + 1'b1;
               end
            end
         end
         ROM: begin
            if (!bus.ioctl_download) begin
               state_n = DONE;
            end else if (bus.ioctl_wr) begin
               if (slot_full) begin
                  overflow_n = 1'b1;
               end else if (in_rom) begin
                  req      = 1'b1;
                  req_addr = bus.ioctl_addr[ADDR_W-1:0] + ADDR_W'(ROM_OFFSET);
               end
            end
         end
         PATCH: begin
            if (slot_ready) begin
               req      = 1'b1;
               req_addr = ADDR_W'(PTR_BASE) + ADDR_W'(idx);
               req_data = ptr_byte(load_end_q[15:0], idx[0]);
               if (idx == 8'(PATCH_LEN - 1)) begin
                  idx_n = '0;
`ifdef PRG_LOADER_AUTORUN_EN
                  state_n = AUTORUN;
`else
                  state_n = DONE;
`endif
               end else begin
                  idx_n = idx + 8'd1;
               end
            end
         end
`ifdef PRG_LOADER_AUTORUN_EN
         AUTORUN: begin
            if (slot_ready) begin
               req = 1'b1;
               if (idx < 8'(AUTORUN_KEY_COUNT)) begin
                  req_addr = ADDR_W'(KEYBUF_ADDR) + ADDR_W'(idx);
                  req_data = AUTORUN_KEYS[idx[1:0]];
                  idx_n    = idx + 8'd1;
               end else begin
                  req_addr = ADDR_W'(KEYCOUNT_ADDR);
                  req_data = 8'(AUTORUN_KEY_COUNT);
                  idx_n    = '0;
                  state_n  = DONE;
               end
            end
         end
`endif
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   dma_write_slot #(.ADDR_W(ADDR_W)) slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .req_addr (req_addr),
      .req_data (req_data),
      .busy     (bus.dma_busy),
      .full     (slot_full),
      .ready    (slot_ready),
      .we       (bus.dma_we),
      .addr     (bus.dma_addr),
      .data     (bus.dma_din)
   );

   // also high while patch bytes drain, which the HPS ignores once download is low
   assign bus.ioctl_wait = slot_full;
   assign bus.done       = (state == DONE);
   assign bus.load_end   = load_end_q;
   assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_prg_dma_loader.sv
// Directed self-checking bench for prg_dma_loader with a write-level scoreboard model.
`timescale 1ns/1ps
module tb_prg_dma_loader;

   localparam int ADDR_W     = 16;
   localparam int RAM_TOP    = 'h8000;
   localparam int ROM_LO     = 'h0400;
   localparam int ROM_HI     = 'h8000;
   localparam int ROM_OFFSET = 'h8000;
   localparam int PTR_BASE   = 'h002A;
   localparam int PTR_COUNT  = 3;
`ifdef PRG_LOADER_AUTORUN_EN
   localparam int TAIL_LEN     = 2 * PTR_COUNT + 5;
   localparam int PRG_DONE_LAT = 12;
`else
   localparam int TAIL_LEN     = 2 * PTR_COUNT;
   localparam int PRG_DONE_LAT = 7;
`endif

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  sb[$];
   wr_t  seen[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   done_count  = 0;
   logic clk         = 1'b0;
   logic reset_n     = 1'b1;

   prg_dma_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prg_dma_loader #(.ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic expectWrite(input logic [15:0] a, input logic [7:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      sb.push_back(w);
   endtask

   // Model: data lands at start.. until RAM_TOP, then pointer bytes of the end address
   task automatic modelPrg(input logic [15:0] start, input int n, input logic [7:0] first,
                           output logic [15:0] end_addr, output logic ovf);
      int p;
      p   = int'(start);
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (p < RAM_TOP) begin
            expectWrite(16'(p), first + 8'(i * 'h11));
            p++;
         end else begin
            ovf = 1'b1;
         end
      end
      end_addr = 16'(p);
      for (int k = 0; k < 2 * PTR_COUNT; k++)
         expectWrite(16'(PTR_BASE + k), (k % 2 == 1) ? end_addr[15:8] : end_addr[7:0]);
`ifdef PRG_LOADER_AUTORUN_EN
      expectWrite(16'h026F, 8'h52);
      expectWrite(16'h0270, 8'h55);
      expectWrite(16'h0271, 8'h4E);
      expectWrite(16'h0272, 8'h0D);
      expectWrite(16'h009E, 8'h04);
`endif
   endtask

   task automatic startLoad(input logic [7:0] index);
      bus.ioctl_index    = index;
      bus.ioctl_download = 1'b1;
      @(posedge clk); #1;
   endtask

   // Sends one byte, honouring ioctl_wait with a bounded wait
   task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
      int n;
      n = 0;
      while (bus.ioctl_wait && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.ioctl_wait) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL wait_timeout: ioctl_wait still 1 after %0d cycles, want 0", n);
      end
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      @(posedge clk); #1;
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic endLoad(output int lat);
      bus.ioctl_download = 1'b0;
      lat = 0;
      while (!bus.done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL done_timeout: done 0 after %0d cycles, want pulse", lat);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic runPrg(input logic [15:0] start, input int n, input logic [7:0] first, input int busy_cycles,
                         output int lat, output logic [15:0] exp_end, output logic exp_ovf);
      modelPrg(start, n, first, exp_end, exp_ovf);
      startLoad(8'h41);
      applyStimulus(25'd0, start[7:0]);
      applyStimulus(25'd1, start[15:8]);
      for (int i = 0; i < n; i++) begin
         applyStimulus(25'(2 + i), first + 8'(i * 'h11));
         if (i == 0 && busy_cycles > 0) begin
            bus.dma_busy = 1'b1;
            for (int c = 0; c < busy_cycles; c++) begin
               @(negedge clk);
               checkOutput("wait_during_busy", 32'(bus.ioctl_wait), 32'd1);
               @(posedge clk); #1;
            end
            bus.dma_busy = 1'b0;
         end
      end
      endLoad(lat);
   endtask

   // Compare process: every DMA write must be the next one the model predicts
   always @(negedge clk) begin : compare
      wr_t e;
      if (reset_n) begin
         checkOutput("we_while_busy", 32'(bus.dma_we & bus.dma_busy), 32'd0);
         if (bus.done) done_count++;
         if (bus.dma_we) begin
            e.addr = bus.dma_addr;
            e.data = bus.dma_din;
            seen.push_back(e);
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_write: got addr %04h data %02h, want no write", bus.dma_addr, bus.dma_din);
            end else begin
               e = sb.pop_front();
               checkOutput("dma_addr", 32'(bus.dma_addr), 32'(e.addr));
               checkOutput("dma_din", 32'(bus.dma_din), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      vectors++;
      miscompares++;
      $display("[TB] FAIL watchdog: simulation still running, want completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      int          lat, d0, n, zp, rom_cnt;
      logic [15:0] exp_end;
      logic        exp_ovf;
      logic [7:0]  d;
      int          rom_offs[$];

      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'h00;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = 8'h00;
      bus.dma_busy       = 1'b0;

      #1 reset_n = 1'b0;
      #10;
      checkOutput("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      checkOutput("rst_we", 32'(bus.dma_we), 32'd0);
      checkOutput("rst_addr", 32'(bus.dma_addr), 32'd0);
      checkOutput("rst_load_end", 32'(bus.load_end), 32'd0);
      checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] test 1: PRG $0401 + AA BB CC");
      seen.delete();
      d0 = done_count;
      runPrg(16'h0401, 3, 8'hAA, 0, lat, exp_end, exp_ovf);
      checkOutput("t1_latency", 32'(lat), 32'(PRG_DONE_LAT));
      checkOutput("t1_load_end", 32'(bus.load_end), 32'h0404);
      checkOutput("t1_load_end_model", 32'(bus.load_end), 32'(exp_end));
      checkOutput("t1_overflow", 32'(bus.overflow), 32'(exp_ovf));
      checkOutput("t1_done_pulses", 32'(done_count - d0), 32'd1);
      checkOutput("t1_writes", 32'(seen.size()), 32'(3 + TAIL_LEN));
      if (seen.size() >= 9) begin
         checkOutput("t1_w0_addr", 32'(seen[0].addr), 32'h0401);
         checkOutput("t1_w0_data", 32'(seen[0].data), 32'hAA);
         checkOutput("t1_w2_addr", 32'(seen[2].addr), 32'h0403);
         checkOutput("t1_w2_data", 32'(seen[2].data), 32'hCC);
         checkOutput("t1_vartab_addr", 32'(seen[3].addr), 32'h002A);
         checkOutput("t1_vartab_lo", 32'(seen[3].data), 32'h04);
         checkOutput("t1_strend_addr", 32'(seen[8].addr), 32'h002F);
         checkOutput("t1_strend_hi", 32'(seen[8].data), 32'h04);
      end
      checkOutput("t1_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] test 2: PRG $7FFE + 4 bytes, overflow");
      seen.delete();
      runPrg(16'h7FFE, 4, 8'h01, 0, lat, exp_end, exp_ovf);
      checkOutput("t2_load_end", 32'(bus.load_end), 32'h8000);
      checkOutput("t2_overflow", 32'(bus.overflow), 32'd1);
      checkOutput("t2_overflow_model", 32'(bus.overflow), 32'(exp_ovf));
      checkOutput("t2_writes", 32'(seen.size()), 32'(2 + TAIL_LEN));
      if (seen.size() >= 4) begin
         checkOutput("t2_last_data_addr", 32'(seen[1].addr), 32'h7FFF);
         checkOutput("t2_ptr_lo", 32'(seen[2].data), 32'h00);
         checkOutput("t2_ptr_hi", 32'(seen[3].data), 32'h80);
      end
      checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] test 3: ROM image");
      seen.delete();
      d0 = done_count;
      rom_offs = '{0, 1, 'h03FF, 'h0400, 'h0401, 'h1234, 'h7FFF, 'h8000, 'hFFFF};
      for (int o = 'h0137; o < 'h10000; o += 'h0E11) rom_offs.push_back(o);
      rom_cnt = 0;
      startLoad(8'h00);
      checkOutput("t3_overflow_cleared", 32'(bus.overflow), 32'd0);
      foreach (rom_offs[i]) begin
         d = 8'(rom_offs[i]) ^ 8'(rom_offs[i] >> 8) ^ 8'h5A;
         if (rom_offs[i] >= ROM_LO && rom_offs[i] < ROM_HI) begin
            expectWrite(16'(rom_offs[i] + ROM_OFFSET), d);
            rom_cnt++;
         end
         applyStimulus(25'(rom_offs[i]), d);
         if (rom_offs[i] == 'h0400) checkOutput("t3_addr_0400", 32'(bus.dma_addr), 32'h8400);
         if (rom_offs[i] == 'h7FFF) checkOutput("t3_addr_7fff", 32'(bus.dma_addr), 32'hFFFF);
      end
      endLoad(lat);
      checkOutput("t3_latency", 32'(lat), 32'd1);
      checkOutput("t3_done_pulses", 32'(done_count - d0), 32'd1);
      checkOutput("t3_writes", 32'(seen.size()), 32'(rom_cnt));
      zp = 0;
      foreach (seen[i]) if (seen[i].addr < 16'h0400) zp++;
      checkOutput("t3_no_low_writes", 32'(zp), 32'd0);
      checkOutput("t3_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] test 4: busy on first data byte");
      seen.delete();
      runPrg(16'h1000, 3, 8'h77, 5, lat, exp_end, exp_ovf);
      checkOutput("t4_load_end", 32'(bus.load_end), 32'h1003);
      checkOutput("t4_overflow", 32'(bus.overflow), 32'd0);
      zp = 0;
      foreach (seen[i]) if (seen[i].addr == 16'h1000) zp++;
      checkOutput("t4_written_once", 32'(zp), 32'd1);
      if (seen.size() >= 1) checkOutput("t4_first_data", 32'(seen[0].data), 32'h77);
      checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] test 5: truncated header");
      seen.delete();
      d0 = done_count;
      startLoad(8'h41);
      applyStimulus(25'd0, 8'h01);
      bus.ioctl_download = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t5_no_done", 32'(done_count - d0), 32'd0);
      checkOutput("t5_no_writes", 32'(seen.size()), 32'd0);
      checkOutput("t5_wait", 32'(bus.ioctl_wait), 32'd0);

      $display("[TB] test 6: reset during patch");
      seen.delete();
      modelPrg(16'h0401, 2, 8'h10, exp_end, exp_ovf);
      startLoad(8'h41);
      applyStimulus(25'd0, 8'h01);
      applyStimulus(25'd1, 8'h04);
      applyStimulus(25'd2, 8'h10);
      applyStimulus(25'd3, 8'h21);
      bus.ioctl_download = 1'b0;
      n = 0;
      while (sb.size() > TAIL_LEN - 2 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      checkOutput("t6_reached_patch", 32'(sb.size()), 32'(TAIL_LEN - 2));
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      checkOutput("t6_we", 32'(bus.dma_we), 32'd0);
      checkOutput("t6_wait", 32'(bus.ioctl_wait), 32'd0);
      checkOutput("t6_load_end", 32'(bus.load_end), 32'd0);
      checkOutput("t6_addr", 32'(bus.dma_addr), 32'd0);
      checkOutput("t6_done", 32'(bus.done), 32'd0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("t6_writes_before_reset", 32'(seen.size()), 32'd4);

      $display("[TB] test 7: PRG after reset");
      seen.delete();
      runPrg(16'h0801, 3, 8'h30, 0, lat, exp_end, exp_ovf);
      checkOutput("t7_latency", 32'(lat), 32'(PRG_DONE_LAT));
      checkOutput("t7_load_end", 32'(bus.load_end), 32'h0804);
      checkOutput("t7_writes", 32'(seen.size()), 32'(3 + TAIL_LEN));
      checkOutput("t7_sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prg_dma_loader.md
Name: prg_dma_loader

Overview:
- Parametrised successor of the in-line PRG/ROM download loader in the PET top level.
- Accepts the HPS ioctl byte stream and writes it into PET memory through the hw DMA port.
- Handles both the PRG load mode (2-byte load-address header) and the raw ROM image mode.
- After a PRG load it patches a configurable list of BASIC zero-page pointers.
- Adds backpressure (ioctl_wait) against a busy DMA port, overflow/truncation status and a done pulse.

Parameters:
ADDR_W, 16, DMA address width
RAM_TOP, 'h8000, first address past writable RAM; PRG bytes at or above it are dropped
PRG_INDEX, 8'h41, ioctl_index selecting PRG mode
ROM_INDEX, 8'h00, ioctl_index selecting ROM mode
ROM_LO, 'h0400, first ROM-file offset accepted
ROM_HI, 'h8000, ROM-file offset limit (exclusive)
ROM_OFFSET, 'h8000, added to the accepted ROM-file offset to form the DMA address
PTR_BASE, 'h002A, zero-page address of the first pointer to patch
PTR_COUNT, 3, number of consecutive 16-bit little-endian pointers patched (VARTAB/ARYTAB/STREND)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download in progress
ioctl_index  in  8  download target selector
ioctl_wr  in  1  byte strobe, one cycle
ioctl_addr  in  25  byte offset in file
ioctl_dout  in  8  byte data
ioctl_wait  out  1  stall request to HPS
dma_addr  out  ADDR_W  write address
dma_din  out  8  write data
dma_we  out  1  write strobe, one cycle
dma_busy  in  1  DMA port cannot accept a write this cycle
load_end  out  ADDR_W  address following the last PRG byte written
overflow  out  1  sticky: PRG data reached RAM_TOP
done  out  1  one-cycle pulse when the load sequence completes

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; load_end=0; internal pointer=0.
- The first cycle of ioctl_download with a matching index clears overflow.
- States: IDLE, HDR, DATA, ROM, PATCH, DONE.
- IDLE:
  - Download rising with index==PRG_INDEX -> HDR.
  - Download rising with index==ROM_INDEX -> ROM.
  - Any other index is ignored.
- HDR:
  - Byte at ioctl_addr 0 -> ptr[7:0]; byte at ioctl_addr 1 -> ptr[15:8].
  - Then -> DATA.
  - Download falling in HDR (truncated file) -> IDLE, no patch, done not pulsed.
- DATA:
  - Each ioctl_wr with ptr<RAM_TOP issues dma_we one cycle later: dma_addr=ptr, dma_din=byte. Then ptr+=1.
  - ptr>=RAM_TOP: byte is dropped, overflow set, ptr not incremented.
  - Download falling -> load_end=ptr -> PATCH.
- ROM:
  - ioctl_wr with ROM_LO<=ioctl_addr<ROM_HI -> dma write to ioctl_addr[ADDR_W-1:0]+ROM_OFFSET, wrapping mod 2^ADDR_W.
  - Other offsets are dropped silently.
  - Download falling -> DONE; no patch.
- Backpressure:
  - A byte awaiting DMA is held in a 1-entry buffer.
  - ioctl_wait=1 from the cycle after ioctl_wr until the cycle its dma_we is issued with dma_busy=0.
  - dma_we is asserted only when dma_busy=0.
  - A back-to-back ioctl_wr while the buffer is full is a protocol error: drop the new byte, set overflow.
- PATCH:
  - Writes 2*PTR_COUNT bytes, alternating lo/hi of load_end, to PTR_BASE+0..2*PTR_COUNT-1.
  - One write per cycle when dma_busy=0; a busy cycle stalls the sequence, no skip.
  - Then -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Latency: without busy, a PRG of N data bytes gives done exactly 2*PTR_COUNT+1 cycles after download falls.
- A new download starting while in PATCH/DONE is ignored until IDLE. A download that is still high on return to IDLE is not restarted; only a rising edge starts a load.
- reset_n low mid-load aborts immediately; no patch writes occur.

Optional Feature:
- Macro: PRG_LOADER_AUTORUN_EN.
- Defined:
  - After PATCH, state AUTORUN writes PETSCII "RUN",$0D to keyboard buffer 'h026F..'h0272, then 4 to count byte 'h009E, before DONE.
  - done latency grows by 5 cycles.
  - Applies to PRG mode only.
- Undefined: AUTORUN state and logic absent; behaviour as above.

Decomposition:
- Package pet_loader_pkg holds:
  - the state enum typedef;
  - BASIC4 constants (PTR_BASE default, keyboard buffer 'h026F, count 'h009E);
  - the autorun PETSCII byte array.
- One natural sub-module, dma_write_slot: 1-entry buffer plus busy handshake, generating ioctl_wait and dma_we. It is reused by DATA, ROM and PATCH through a request mux.

Test Plan:
- PRG $0401 header + 3 bytes AA BB CC, busy=0 -> writes $0401/02/03 = AA/BB/CC; then $2A..$2F = 04 04 04 04 04 04; load_end=$0404; done 7 cycles after falling edge.
- PRG header $7FFE + 4 bytes -> only $7FFE and $7FFF written; overflow=1; pointers patched with $8000.
- ROM index 0, 64 KB file -> writes only for offsets $0400..$7FFF at $8400..$FFFF; no zero-page writes; done pulses.
- dma_busy held high 5 cycles on the first data byte -> ioctl_wait high for those cycles; byte written once, intact; no dropped data.
- Download falls after 1 header byte -> no DMA writes; done never pulses; state IDLE.
- reset_n pulsed low during PATCH after 2 pointer bytes -> outputs 0 asynchronously; no further writes; next PRG load succeeds normally.
